// File: rtl/fpcvt_pkg.sv
// Shared widths, limits and types for the fpcvt datapath.
package fpcvt_pkg;

  localparam int MAG_W = 11;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;

  localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;
  localparam logic [SIG_W-1:0] SIG_MAX = 4'd15;

  typedef logic [MAG_W-1:0] mag_t;
  typedef logic [EXP_W-1:0] exp_t;
  typedef logic [SIG_W-1:0] sig_t;

endpackage

// File: rtl/fpcvt_lead_one.sv
// Priority encoder on the upper magnitude bits [10:4].
// Returns the raw exponent: (leading-one index - 3), or 0 when no upper bit is set.
module fpcvt_lead_one
  import fpcvt_pkg::*;
(
  input  logic [6:0] upper,
  output exp_t       exponent
);

  // Scan upward so the highest set bit wins; bit 0 of upper is magnitude bit 4.
  always_comb begin
    exponent = '0;
    for (int i = 0; i < 7; i++) begin
      if (upper[i]) exponent = exp_t'(i + 1);
    end
  end

endmodule

// File: rtl/fp_convert.sv
// Linear 11-bit magnitude to 3-bit exponent / 4-bit significand, one register stage.
// Optional feature macro: FP_CONVERT_ROUND_EN enables round-half-up with
// carry into the exponent and saturation at the top; otherwise truncation.
module fp_convert
  import fpcvt_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  mag_t magnitude,
  output exp_t exponent,
  output sig_t significand,
  output logic out_valid
);

  exp_t raw_exp;
  sig_t raw_sig;
  exp_t next_exp;
  sig_t next_sig;

  fpcvt_lead_one u_lead_one (
    .upper    (magnitude[10:4]),
    .exponent (raw_exp)
  );

  // Significand window: the four bits starting at the raw exponent.
  always_comb begin
    raw_sig = sig_t'(magnitude >> raw_exp);
  end

`ifdef FP_CONVERT_ROUND_EN
  logic       round_bit;
  logic [4:0] rounded;

  // Round half-up using the bit just below the window; a carry out renormalises
  // to 1000 at the next exponent, or saturates when already at the top exponent.
  always_comb begin
    round_bit = 1'({magnitude, 1'b0} >> raw_exp);
    rounded   = {1'b0, raw_sig} + {4'b0000, round_bit};
    next_exp  = raw_exp;
    next_sig  = rounded[3:0];
    if (rounded[4]) begin
      if (raw_exp == EXP_MAX) begin
        next_exp = EXP_MAX;
        next_sig = SIG_MAX;
      end else begin
        next_exp = raw_exp + 3'd1;
        next_sig = 4'b1000;
      end
    end
  end
`else
  // Truncation: the window is passed through unchanged.
  always_comb begin
    next_exp = raw_exp;
    next_sig = raw_sig;
  end
`endif

  // Output registers: capture on valid, hold otherwise; reset wins over valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exponent    <= '0;
      significand <= '0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        exponent    <= next_exp;
        significand <= next_sig;
      end
    end
  end

endmodule

// File: tb/tb_fp_convert.sv
// Self-checking bench for fp_convert; works with or without FP_CONVERT_ROUND_EN.
module tb_fp_convert;
  import fpcvt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  mag_t magnitude = '0;
  exp_t exponent;
  sig_t significand;
  logic out_valid;

  int checks = 0;
  int failures = 0;

  int held_exp = 0;
  int held_sig = 0;

  fp_convert dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .magnitude   (magnitude),
    .exponent    (exponent),
    .significand (significand),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  // Reference: value ~= sig * 2^exp, computed from the conversion rules.
  task automatic model(input int m, output int e, output int s);
    int p;
    p = -1;
    for (int i = 0; i < 11; i++) if ((m >> i) & 1) p = i;
    e = (p >= 4) ? p - 3 : 0;
    s = (m >> e) % 16;
`ifdef FP_CONVERT_ROUND_EN
    if (e > 0) s = s + ((m >> (e - 1)) % 2);
    if (s == 16) begin
      if (e < 7) begin
        e = e + 1;
        s = 8;
      end else begin
        s = 15;
      end
    end
`endif
  endtask

  task automatic check_result(input string name, input int exp_e, input int exp_s, input logic exp_v);
    checks++;
    if (out_valid !== exp_v || exponent !== exp_t'(exp_e) || significand !== sig_t'(exp_s)) begin
      failures++;
      $display("[TB] FAIL %s: got v=%0b e=%0d s=%0d, want v=%0b e=%0d s=%0d",
               name, out_valid, exponent, significand, exp_v, exp_e, exp_s);
    end
  endtask

  // One cycle of stimulus, checked one edge later.
  task automatic drive_cycle(input string name, input logic v, input int m);
    int e, s;
    @(negedge clk);
    in_valid  = v;
    magnitude = mag_t'(m);
    @(posedge clk);
    #1;
    if (v) begin
      model(m, e, s);
      held_exp = e;
      held_sig = s;
    end
    check_result(name, held_exp, held_sig, v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    magnitude = 11'd2047;
    repeat (2) @(posedge clk);
    #1;
    check_result("reset_state", 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    held_exp = 0;
    held_sig = 0;
  endtask

  task automatic test_directed();
    int vec[8] = '{15, 0, 422, 46, 124, 2047, 1024, 16};
    foreach (vec[i]) drive_cycle($sformatf("directed_%0d", vec[i]), 1'b1, vec[i]);
    // Literal expectations for the headline cases, independent of the model.
    drive_cycle("lit_46", 1'b1, 46);
`ifdef FP_CONVERT_ROUND_EN
    check_result("lit_46_round", 2, 12, 1'b1);
    drive_cycle("lit_124", 1'b1, 124);
    check_result("lit_124_carry", 4, 8, 1'b1);
`else
    check_result("lit_46_trunc", 2, 11, 1'b1);
    drive_cycle("lit_124", 1'b1, 124);
    check_result("lit_124_trunc", 3, 15, 1'b1);
`endif
    drive_cycle("lit_2047", 1'b1, 2047);
    check_result("lit_2047_sat", 7, 15, 1'b1);
    drive_cycle("lit_422", 1'b1, 422);
    check_result("lit_422", 5, 13, 1'b1);
  endtask

  task automatic test_back_to_back();
    drive_cycle("b2b_0", 1'b1, 300);
    drive_cycle("b2b_1", 1'b1, 77);
    drive_cycle("b2b_2", 1'b1, 1500);
    drive_cycle("hold_0", 1'b0, 5);
    drive_cycle("hold_1", 1'b0, 2000);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      int m;
      logic v;
      m = int'($urandom_range(0, 2047)) >> $urandom_range(0, 10);
      v = ($urandom_range(0, 3) != 0);
      drive_cycle("random", v, m);
    end
  endtask

  task automatic test_reset_during_valid();
    drive_cycle("pre_reset", 1'b1, 1000);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1;
    magnitude = 11'd2047;
    @(posedge clk);
    #1;
    check_result("reset_dominates", 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    held_exp = 0;
    held_sig = 0;
    @(posedge clk);
    #1;
    check_result("after_reset_no_result", 0, 0, 1'b0);
    drive_cycle("post_reset", 1'b1, 999);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_during_valid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
